// File: rtl/tone_player_pkg.sv
// Shared types, widths and helpers for the tone playback engine.
package tone_player_pkg;

    localparam int unsigned TONE_W         = 32;
    localparam int unsigned BEAT_W         = 8;
    localparam int unsigned SILENCE_HZ_DEF = 20000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int unsigned beat_div(input int unsigned clk_hz,
                                             input int unsigned beat_hz);
        return clk_hz / beat_hz;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, valid 32 cycles after start.
module tone_divider
    import tone_player_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TONE_W-1:0] dividend,
    input  logic [TONE_W-1:0] divisor,
    output logic [TONE_W-1:0] quotient,
    output logic              valid
);

    logic [TONE_W-1:0] rem_q, quo_q, dsr_q;
    logic [4:0]        cnt_q;
    logic              busy_q, valid_q;

    logic [TONE_W-1:0] src_rem, src_quo, dsr;
    logic [TONE_W:0]   rem_sh, diff;
    logic [TONE_W-1:0] step_rem, step_quo;

    // The first step runs on the start edge so the result lands 32 cycles later.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        dsr      = start ? divisor : dsr_q;
        rem_sh   = {src_rem, src_quo[TONE_W-1]};
        diff     = rem_sh - {1'b0, dsr};
        step_quo = {src_quo[TONE_W-2:0], ~diff[TONE_W]};
        step_rem = diff[TONE_W] ? rem_sh[TONE_W-1:0] : diff[TONE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (start) begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            dsr_q   <= divisor;
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (abort) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign valid    = valid_q;

endmodule

// File: rtl/tone_player.sv
// Song playback engine: steps the beat index, tracks the looked-up tone and drives a square wave.
module tone_player
    import tone_player_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BEAT_HZ    = 8,
    parameter int unsigned SONG_LEN   = 256,
    parameter int unsigned SILENCE_HZ = SILENCE_HZ_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [TONE_W-1:0] tone,
    output logic [BEAT_W-1:0] ibeat_num,
    output logic              audio,
    output logic              playing,
    output logic              done
);

    localparam int unsigned BEAT_DIV = beat_div(CLK_HZ, BEAT_HZ);

    state_t            state_q, state_d;
    logic [31:0]       btimer_q, btimer_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              done_q, done_d, playing_q;
    logic [TONE_W-1:0] tone_q, hp_q, hcnt_q, hcnt_d, quotient;
    logic              hp_ok_q, audio_q, audio_d, div_valid;
    logic              tone_chg, new_mute, mute, active;

    assign tone_chg = (tone != tone_q);
    assign new_mute = (tone == '0) || (tone >= TONE_W'(SILENCE_HZ));
    assign mute     = (tone_q == '0) || (tone_q >= TONE_W'(SILENCE_HZ));

    tone_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tone_chg && !new_mute),
        .abort    (tone_chg && new_mute),
        .dividend (TONE_W'(CLK_HZ)),
        .divisor  (tone << 1),
        .quotient (quotient),
        .valid    (div_valid)
    );

    always_comb begin
        state_d  = state_q;
        btimer_d = btimer_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        if (stop) begin
            state_d  = ST_IDLE;
            btimer_d = '0;
            beat_d   = '0;
        end else if (start) begin
            state_d  = ST_PLAY;
            btimer_d = '0;
            beat_d   = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (btimer_q == 32'(BEAT_DIV - 1)) begin
                        btimer_d = '0;
                        if (beat_q == BEAT_W'(SONG_LEN - 1)) begin
                            if (loop) begin
                                beat_d = '0;
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        btimer_d = btimer_q + 32'd1;
                    end
                end
                ST_PAUSE: if (!pause) state_d = ST_PLAY;
                default:  btimer_d = '0;
            endcase
        end
    end

    // A shorter new half period wraps at once instead of running out the old count.
    assign active = (state_d == ST_PLAY) && !mute && hp_ok_q;

    always_comb begin
        hcnt_d  = '0;
        audio_d = 1'b0;
        if (active) begin
            if (hcnt_q >= hp_q - 1'b1) begin
                audio_d = ~audio_q;
            end else begin
                hcnt_d  = hcnt_q + 1'b1;
                audio_d = audio_q;
            end
        end else if (state_d == ST_PAUSE) begin
            hcnt_d = hcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            btimer_q  <= '0;
            beat_q    <= '0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
            tone_q    <= '0;
            hp_q      <= '0;
            hp_ok_q   <= 1'b0;
            hcnt_q    <= '0;
            audio_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            btimer_q  <= btimer_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            playing_q <= (state_d == ST_PLAY) || (state_d == ST_PAUSE);
            tone_q    <= tone;
            hcnt_q    <= hcnt_d;
            audio_q   <= audio_d;
            if (tone_chg && new_mute) begin
                hp_ok_q <= 1'b0;
            end else if (div_valid && !mute) begin
                hp_q    <= (quotient == '0) ? TONE_W'(1) : quotient;
                hp_ok_q <= 1'b1;
            end
        end
    end

    assign ibeat_num = beat_q;
    assign audio     = audio_q;
    assign playing   = playing_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player at 1000 cycles per beat and a four-beat song.
module tb_tone_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop = 1'b0;
    logic [31:0] tone = 32'd500;
    logic [7:0]  ibeat_num;
    logic        audio, playing, done;

    int n_assert = 0;
    int n_fail = 0;
    int done_seen = 0;
    int d0;
    int per;

    tone_player #(
        .CLK_HZ     (1000000),
        .BEAT_HZ    (1000),
        .SONG_LEN   (4),
        .SILENCE_HZ (20000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop      (loop),
        .tone      (tone),
        .ibeat_num (ibeat_num),
        .audio     (audio),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles until audio next changes; -1 if it never does within the bound.
    task automatic edges_to_toggle(output int n);
        logic a;
        a = audio;
        n = 0;
        while (audio === a && n < 5000) begin
            step(1);
            n++;
        end
        if (n >= 5000) n = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_beat", ibeat_num, 0);
        chk("rst_audio", audio, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(40);

        // Plain playback, 500 Hz, no loop
        d0 = done_seen;
        pulse_start();
        chk("p_playing", playing, 1);
        chk("p_beat0", ibeat_num, 0);
        chk("p_audio0", audio, 0);
        step(998);  chk("p_audio_e998", audio, 0);
        step(1);    chk("p_audio_e999", audio, 1);
        step(1);    chk("p_beat1", ibeat_num, 1);
        step(999);  chk("p_audio_e1999", audio, 0);
        step(1);    chk("p_beat2", ibeat_num, 2);
        step(1000); chk("p_beat3", ibeat_num, 3);
        chk("p_audio_e3000", audio, 1);
        step(999);  chk("p_done_early", done, 0);
        chk("p_playing_e3999", playing, 1);
        step(1);    chk("end_done", done, 1);
        chk("end_beat", ibeat_num, 3);
        chk("end_playing", playing, 0);
        chk("end_audio", audio, 0);
        step(1);    chk("end_done_drop", done, 0);
        chk("end_beat_hold", ibeat_num, 3);
        chk("end_done_count", done_seen - d0, 1);

        // Looping playback
        loop = 1'b1;
        d0 = done_seen;
        pulse_start();
        chk("l_beat0", ibeat_num, 0);
        step(3000); chk("l_beat3", ibeat_num, 3);
        step(1000); chk("l_wrap0", ibeat_num, 0);
        chk("l_playing", playing, 1);
        step(1000); chk("l_beat1", ibeat_num, 1);
        chk("l_no_done", done_seen - d0, 0);

        // Rest tones while beats keep running
        tone = 32'd20000;
        step(2);    chk("m_audio_sil", audio, 0);
        step(998);  chk("m_beat2", ibeat_num, 2);
        chk("m_audio_sil2", audio, 0);
        tone = 32'd0;
        step(500);  chk("m_audio_zero", audio, 0);
        tone = 32'd250;
        step(2032); chk("m_audio_e8532", audio, 0);
        chk("m_beat_e8532", ibeat_num, 0);
        step(1);    chk("m_audio_e8533", audio, 1);
        step(1999); chk("m_audio_e10532", audio, 1);
        step(1);    chk("m_audio_e10533", audio, 0);
        chk("m_beat_e10533", ibeat_num, 2);

        // Stop, then pause mid-beat
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("s_beat", ibeat_num, 0);
        chk("s_playing", playing, 0);
        chk("s_audio", audio, 0);
        pulse_start();
        step(1000); chk("q_beat1", ibeat_num, 1);
        step(400);
        pause = 1'b1;
        step(1);    chk("q_audio_paused", audio, 0);
        chk("q_playing_paused", playing, 1);
        step(1599); chk("q_audio_mid", audio, 0);
        chk("q_beat_mid", ibeat_num, 1);
        step(1400);
        pause = 1'b0;
        step(600);  chk("q_beat_hold", ibeat_num, 1);
        step(1);    chk("q_beat2", ibeat_num, 2);

        // Back-to-back tone changes restart the divide; 1000 Hz wins
        tone = 32'd500;
        step(1);
        tone = 32'd1000;
        step(100);
        edges_to_toggle(per);
        edges_to_toggle(per);
        chk("t_half_period", per, 500);
        edges_to_toggle(per);
        chk("t_half_period2", per, 500);

        // Simultaneous start and stop
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_playing", playing, 0);
        chk("ss_beat", ibeat_num, 0);
        step(5);    chk("ss_audio", audio, 0);
        chk("ss_idle", playing, 0);

        // Asynchronous reset between edges
        pulse_start();
        step(1500);
        chk("r_pre_beat", ibeat_num, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_beat", ibeat_num, 0);
        chk("r_audio", audio, 0);
        chk("r_playing", playing, 0);
        chk("r_done", done, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Playback engine on the consumer side of the beat-to-tone lookup.
- Sequences the 8-bit beat index fed to the lookup and accepts the 32-bit tone frequency (Hz) it returns.
- Synthesizes a 50%-duty square wave on the audio pin.
- Provides start/stop/pause/loop control, silence detection, and an end-of-song pulse.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BEAT_HZ, 8, beat-index advance rate (quarter-beat steps per second)
SONG_LEN, 256, number of beat indices per song (index 0..SONG_LEN-1, max 256)
SILENCE_HZ, 20000, tone values >= this are treated as rest

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin playback at beat 0
stop  in  1  pulse: abort playback, return to idle
pause  in  1  level: 1 holds playback
loop  in  1  level: 1 wraps to beat 0 at song end
tone  in  32  frequency in Hz for current ibeat_num
ibeat_num  out  8  current beat index to tone lookup
audio  out  1  square-wave speaker output
playing  out  1  high in PLAY or PAUSE
done  out  1  one-cycle pulse at non-looping song end

Behaviour:
Reset:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- rst_n low: state IDLE, ibeat_num=0, audio=0, playing=0, done=0, all counters 0, divider idle.
State machine (IDLE, PLAY, PAUSE, DONE):
- IDLE/DONE + start -> PLAY; ibeat_num=0, beat timer=0.
- PLAY + pause -> PAUSE; PAUSE + !pause -> PLAY. Timers resume where held.
- PLAY/PAUSE + start -> PLAY at beat 0 (restart).
- Any state + stop -> IDLE; ibeat_num=0, audio=0.
- stop and start in the same cycle: stop wins.
- Song end in PLAY, i.e. beat tick with ibeat_num==SONG_LEN-1:
  - loop=1 -> ibeat_num=0, stay in PLAY.
  - loop=0 -> DONE; done=1 for exactly one cycle; ibeat_num holds last value; audio=0.
Beat timer:
- Counts 0..CLK_HZ/BEAT_HZ-1 in PLAY only; held in PAUSE; cleared in IDLE/DONE.
- Wrap cycle is the beat tick. ibeat_num updates the cycle after the tick (registered output).
Tone path:
- tone is sampled every cycle and compared with the registered copy tone_q.
- On any difference: tone_q<=tone, divider (re)started. An in-flight divide is aborted and restarted with the newest tone.
- Mute condition: tone_q==0 or tone_q>=SILENCE_HZ. When muted, audio=0 and the half-period counter is held at 0. No divide is started for mute values.
- Otherwise half_period = floor(CLK_HZ / (2*tone_q)), 32-bit unsigned, quotient saturated to a minimum of 1.
- Divider latency is 32 cycles from start to valid. Until valid, the previous half_period stays in use; a fresh start from mute keeps audio=0 until valid.
- Half-period counter counts 0..half_period-1 in PLAY; audio toggles on wrap.
- A new half_period takes effect at the next toggle, or immediately if the current count >= the new value (no long glitch period).
- PAUSE/IDLE/DONE: audio forced 0; counter held in PAUSE, cleared in IDLE/DONE.
- playing = (state==PLAY || state==PAUSE), registered.

Decomposition:
- Package tone_player_pkg:
  - state enum (IDLE, PLAY, PAUSE, DONE)
  - TONE_W=32, BEAT_W=8
  - SILENCE_HZ default
  - function computing beat divisor CLK_HZ/BEAT_HZ
- Sub-module tone_divider:
  - 32-bit restoring radix-2 unsigned divider, one quotient bit per cycle.
  - Ports: clk, rst_n, start, abort, dividend[31:0], divisor[31:0], quotient[31:0], valid.
  - Dividend is the constant CLK_HZ; divisor is 2*tone_q.
- Top module holds the FSM, beat timer, and half-period counter.

Test Plan (bench parameters: CLK_HZ=1000000, BEAT_HZ=1000, i.e. 1000 cycles/beat, SONG_LEN=4):
- Reset then start, tone held 500 -> ibeat_num steps 0,1,2,3 every 1000 cycles; after divide, audio toggles every 1000 cycles (500 Hz); playing=1.
- loop=0, run to end -> exactly one done pulse, one cycle after 4000 cycles; state DONE; audio=0; ibeat_num=3; playing=0.
- loop=1 -> ibeat_num sequence 0,1,2,3,0,1 with no done pulse.
- tone=20000 or tone=0 mid-play -> audio stays 0 while beats keep advancing; return to tone=250 -> toggles every 2000 cycles after 32-cycle divide.
- pause asserted at beat 1 cycle 400 for 3000 cycles -> audio=0; beat 2 arrives 600 cycles after release.
- Change tone 500->1000 on consecutive cycles during a divide, and start+stop together -> final half_period 500; start+stop leaves state IDLE, ibeat_num=0.
- rst_n low mid-play (asynchronous, between edges) -> all outputs 0 immediately.
